// File: rtl/mcu_pkg.sv
// Shared definitions for the accumulator MCU control unit: opcodes, FSM encoding, acc-source codes, control word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcu_pkg;

  // Opcode map, IR[7:4]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MOVA = 4'h9;
  localparam logic [3:0] OP_MOVR = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // FSM state encoding
  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  // Accumulator source select; bit 1 alone picks the ALU
  localparam logic [1:0] ACC_SRC_REG = 2'b00;
  localparam logic [1:0] ACC_SRC_IMM = 2'b01;
  localparam logic [1:0] ACC_SRC_ALU = 2'b10;

  // Raw per-opcode controls; the FSM qualifies them with state and flags
  typedef struct packed {
    logic       sel_pc;
    logic       load_pc;
    logic       jmp_on_z;   // load_pc only when Z is set
    logic       jmp_on_c;   // load_pc only when C is set
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       upd_flags;  // latch ALU Z/C at end of EXECUTE
    logic       halt;
  } ctrl_word_t;

endpackage

// File: rtl/mcu_op_decode.sv
// Pure combinational opcode to raw control word decode.
// Latency: 0 cycles (combinational).
// Backpressure: none; output is valid whenever opcode is.
module mcu_op_decode
  import mcu_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_word_t cw
);

  // Map each opcode to its datapath controls; unlisted fields stay 0
  always_comb begin
    cw = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        cw.sel_alu   = opcode;
        cw.sel_acc   = ACC_SRC_ALU;
        cw.load_acc  = 1'b1;
        cw.upd_flags = 1'b1;
      end
      OP_MOVA: begin
        cw.sel_acc  = ACC_SRC_REG;
        cw.load_acc = 1'b1;
      end
      OP_MOVR: cw.load_reg = 1'b1;
      OP_LDI: begin
        cw.sel_acc  = ACC_SRC_IMM;
        cw.load_acc = 1'b1;
      end
      OP_JMP: begin
        cw.sel_pc  = 1'b1;
        cw.load_pc = 1'b1;
      end
      OP_JZ: begin
        cw.sel_pc   = 1'b1;
        cw.load_pc  = 1'b1;
        cw.jmp_on_z = 1'b1;
      end
      OP_JC: begin
        cw.sel_pc   = 1'b1;
        cw.load_pc  = 1'b1;
        cw.jmp_on_c = 1'b1;
      end
      OP_HALT: cw.halt = 1'b1;
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mcu_control_fsm.sv
// MCU control unit: FETCH/DECODE/EXECUTE sequencer, datapath strobes, Z/C flags; optional retire counter (MCU_CTRL_DEBUG_EN).
// Latency: 3 cycles per instruction; strobes are combinational from state + IR, flags update on the edge ending EXECUTE.
// Backpressure: none; only HALT stalls, released by the Resume level.
module mcu_control_fsm
  import mcu_pkg::*;
#(
  parameter int IR_W      = 8,
  parameter int ALU_SEL_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [IR_W-1:0]      IR,
  input  logic                 AluZero,
  input  logic                 AluCarry,
  input  logic                 Resume,
  output logic                 LoadIR,
  output logic                 IncPC,
  output logic                 SelPC,
  output logic                 LoadPC,
  output logic                 LoadReg,
  output logic                 LoadAcc,
  output logic [1:0]           SelAcc,
  output logic [ALU_SEL_W-1:0] SelALU,
  output logic                 ZeroFlag,
  output logic                 CarryFlag,
  output logic                 Halted
`ifdef MCU_CTRL_DEBUG_EN
  ,
  output logic [CNT_W-1:0]     RetireCnt
`endif
);

  logic [2:0] state_q, state_d;
  logic       zero_q, carry_q;
  ctrl_word_t cw;

  // Operand nibble is consumed by the datapath, not by the control unit
  logic ir_operand_unused;
  assign ir_operand_unused = ^IR[IR_W-5:0];

  mcu_op_decode u_op_decode (
    .opcode (IR[IR_W-1:IR_W-4]),
    .cw     (cw)
  );

  // Next-state: fixed 3-cycle instruction loop, HALT parks until Resume
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = cw.halt ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = Resume ? ST_FETCH : ST_HALT;
      default:    state_d = ST_INIT;
    endcase
  end

  // State register; reset mid-instruction aborts back to INIT
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Strobes: FETCH loads IR and bumps PC, EXECUTE applies the decoded word.
  // SelPC follows the jump opcode even when a conditional jump is not taken;
  // with LoadPC low the PC mux select has no effect, so that jump is a NOP.
  always_comb begin
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelAcc  = ACC_SRC_REG;
    SelALU  = '0;
    Halted  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        LoadIR = 1'b1;
        IncPC  = 1'b1;
      end
      ST_EXECUTE: begin
        SelPC   = cw.sel_pc;
        LoadPC  = cw.load_pc & (~cw.jmp_on_z | zero_q) & (~cw.jmp_on_c | carry_q);
        LoadReg = cw.load_reg;
        LoadAcc = cw.load_acc;
        SelAcc  = cw.sel_acc;
        SelALU  = ALU_SEL_W'(cw.sel_alu);
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  // Status flags: captured only when an ALU op retires
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (state_q == ST_EXECUTE && cw.upd_flags) begin
      zero_q  <= AluZero;
      carry_q <= AluCarry;
    end
  end

  assign ZeroFlag  = zero_q;
  assign CarryFlag = carry_q;

`ifdef MCU_CTRL_DEBUG_EN
  logic [CNT_W-1:0] retire_q;

  // Saturating retire count: one per EXECUTE exit, parked HALT cycles do not count
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                       retire_q <= '0;
    else if (state_q == ST_EXECUTE && retire_q != '1) retire_q <= retire_q + CNT_W'(1);
  end

  assign RetireCnt = retire_q;
`endif

endmodule
